// File: rtl/onehot_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_scan_decoder_pkg
// Description : Shared state encoding, scan-direction constants and the
//               one-hot expansion helper for the one-hot scan decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    // The helper works at the widest supported size; callers cast the result
    // down to their own N, so SEL_W is limited to C_MAX_SEL_W.
    localparam int C_MAX_SEL_W = 8;
    localparam int C_MAX_N     = 2 ** C_MAX_SEL_W;

    function automatic logic [C_MAX_N-1:0] onehot_of(input logic [C_MAX_SEL_W-1:0] index);
        logic [C_MAX_N-1:0] v;
        v        = '0;
        v[index] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_scan_decoder_bit_pick.sv
`default_nettype none
// ============================================================================
// Module      : onehot_scan_decoder_bit_pick
// Description : Combinational priority picker returning the lowest (ascending)
//               or highest (descending) set bit of a vector.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_scan_decoder_bit_pick
    import onehot_scan_decoder_pkg::*;
#(
    parameter  int N     = 16,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    input  logic             dir,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    // Scanning toward the favoured end lets the last match win.
    always_comb begin
        idx = '0;
        any = 1'b0;
        if (dir == DIR_ASC) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = SEL_W'(i);
                    any = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    idx = SEL_W'(i);
                    any = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/onehot_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_scan_decoder
// Description : Registered index-to-one-hot decoder with a register-list scan
//               mode for load/store-multiple sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_scan_decoder
    import onehot_scan_decoder_pkg::*;
#(
    parameter  int SEL_W = 4,
    localparam int N     = 2 ** SEL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             start,
    input  logic [N-1:0]     mask_in,
    input  logic             dir,
    input  logic             ready,
    output logic [N-1:0]     onehot_out,
    output logic [SEL_W-1:0] index_out,
    output logic             valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [N-1:0]     r_onehot;
    logic [SEL_W-1:0] r_index;
    logic             r_valid;
    logic             r_last;
    logic             r_done;
    logic             r_dir;
    logic [N-1:0]     r_remaining;

    logic [N-1:0]     w_pickVec;
    logic             w_pickDir;
    logic [SEL_W-1:0] w_pickIdx;
    logic             w_pickAny;
    logic [N-1:0]     w_pickOnehot;
    logic [N-1:0]     w_pickCleared;
    logic [N-1:0]     w_selOnehot;

    // One picker serves both the fresh mask in IDLE and the leftover list in SCAN.
    assign w_pickVec = (r_state == SCAN) ? r_remaining : mask_in;
    assign w_pickDir = (r_state == SCAN) ? r_dir       : dir;

    onehot_scan_decoder_bit_pick #(
        .N (N)
    ) u_bitPick (
        .vec (w_pickVec),
        .dir (w_pickDir),
        .idx (w_pickIdx),
        .any (w_pickAny)
    );

    assign w_pickOnehot  = N'(onehot_of(C_MAX_SEL_W'(w_pickIdx)));
    assign w_pickCleared = w_pickVec & ~w_pickOnehot;
    assign w_selOnehot   = N'(onehot_of(C_MAX_SEL_W'(sel_in)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_onehot    <= '0;
            r_index     <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_dir       <= DIR_ASC;
            r_remaining <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dir <= dir;
                        if (w_pickAny) begin
                            r_onehot    <= w_pickOnehot;
                            r_index     <= w_pickIdx;
                            r_valid     <= 1'b1;
                            r_remaining <= w_pickCleared;
                            r_last      <= (w_pickCleared == '0);
                            r_state     <= SCAN;
                        end else begin
                            // Empty list completes immediately without any element.
                            r_done <= 1'b1;
                        end
                    end else if (en) begin
                        r_onehot <= w_selOnehot;
                        r_index  <= sel_in;
                        r_valid  <= 1'b1;
                        r_last   <= 1'b0;
                        r_state  <= SINGLE;
                    end
                end

                SINGLE: begin
                    if (ready) begin
                        r_onehot <= '0;
                        r_index  <= '0;
                        r_valid  <= 1'b0;
                        r_last   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end

                SCAN: begin
                    if (ready) begin
                        if (w_pickAny) begin
                            r_onehot    <= w_pickOnehot;
                            r_index     <= w_pickIdx;
                            r_remaining <= w_pickCleared;
                            r_last      <= (w_pickCleared == '0);
                        end else begin
                            r_onehot <= '0;
                            r_index  <= '0;
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= IDLE;
                        end
                    end
                end

                default: begin
                    r_onehot    <= '0;
                    r_index     <= '0;
                    r_valid     <= 1'b0;
                    r_last      <= 1'b0;
                    r_remaining <= '0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign onehot_out = r_onehot;
    assign index_out  = r_index;
    assign valid      = r_valid;
    assign last       = r_last;
    assign done       = r_done;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_onehot_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_scan_decoder
// Description : Directed and randomized bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_scan_decoder;

    localparam int SEL_W = 4;
    localparam int N     = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             en;
    logic [SEL_W-1:0] sel_in;
    logic             start;
    logic [N-1:0]     mask_in;
    logic             dir;
    logic             ready;
    logic [N-1:0]     onehot_out;
    logic [SEL_W-1:0] index_out;
    logic             valid;
    logic             last;
    logic             busy;
    logic             done;

    onehot_scan_decoder #(
        .SEL_W (SEL_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .sel_in     (sel_in),
        .start      (start),
        .mask_in    (mask_in),
        .dir        (dir),
        .ready      (ready),
        .onehot_out (onehot_out),
        .index_out  (index_out),
        .valid      (valid),
        .last       (last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int   vecCount = 0;
    int   errCount = 0;

    // Model: mode 0 idle, 1 single, 2 scan; mQ holds the elements still to be shown.
    int   mMode = 0;
    int   mQ[$];
    logic mDone = 1'b0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep();
        logic doneNext;
        doneNext = 1'b0;
        if (reset) begin
            mMode = 0;
            mQ.delete();
        end else begin
            case (mMode)
                0: begin
                    if (start) begin
                        mQ.delete();
                        for (int k = 0; k < N; k++) begin
                            int b;
                            b = dir ? (N - 1 - k) : k;
                            if (mask_in[b]) mQ.push_back(b);
                        end
                        if (mQ.size() == 0) doneNext = 1'b1;
                        else mMode = 2;
                    end else if (en) begin
                        mQ.delete();
                        mQ.push_back(int'(sel_in));
                        mMode = 1;
                    end
                end
                1: begin
                    if (ready) begin
                        mQ.delete();
                        mMode = 0;
                    end
                end
                default: begin
                    if (ready) begin
                        void'(mQ.pop_front());
                        if (mQ.size() == 0) begin
                            mMode    = 0;
                            doneNext = 1'b1;
                        end
                    end
                end
            endcase
        end
        mDone = doneNext;
    endtask

    task automatic checkOutputs();
        logic [N-1:0] eOh;
        int           eIdx;
        eOh  = '0;
        eIdx = 0;
        if (mMode != 0) begin
            eIdx = mQ[0];
            eOh  = N'(1) << eIdx;
        end
        checkVal("onehot", 32'(onehot_out), 32'(eOh));
        checkVal("index",  32'(index_out),  32'(eIdx));
        checkVal("valid",  32'(valid),      32'(mMode != 0));
        checkVal("last",   32'(last),       32'(mMode == 2 && mQ.size() == 1));
        checkVal("busy",   32'(busy),       32'(mMode != 0));
        checkVal("done",   32'(done),       32'(mDone));
    endtask

    task automatic tick();
        @(posedge clock);
        modelStep();
        #1;
        checkOutputs();
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; en = 1'b1; dir = 1'b0; ready = 1'b0;
        sel_in = '0; mask_in = 16'hFFFF;
        tick(); tick();
        reset = 1'b0; start = 1'b0; en = 1'b0;
        tick();

        // Single decode of index 11
        sel_in = 4'hB; en = 1'b1; ready = 1'b1;
        tick();
        en = 1'b0;
        repeat (3) tick();

        // Ascending scan
        mask_in = 16'h8421; dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();

        // Descending scan with a stall on the first element
        mask_in = 16'h0006; dir = 1'b1; start = 1'b1; ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        ready = 1'b1;
        repeat (4) tick();

        // Empty mask
        mask_in = '0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();

        // start wins over en, then start during SCAN is ignored
        mask_in = 16'h0030; dir = 1'b0; start = 1'b1; en = 1'b1; sel_in = 4'h2;
        tick();
        en = 1'b0; mask_in = 16'hFFFF; ready = 1'b0;
        repeat (2) tick();
        ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();

        // Abort a full scan after the second element
        mask_in = 16'hFFFF; dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        mask_in = 16'h0101; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();

        // Randomized traffic
        repeat (3000) begin
            reset  = ($urandom_range(99) == 0);
            start  = ($urandom_range(3) == 0);
            en     = ($urandom_range(2) == 0);
            ready  = ($urandom_range(3) != 0);
            dir    = 1'($urandom);
            sel_in = SEL_W'($urandom);
            case ($urandom_range(3))
                0:       mask_in = '0;
                1:       mask_in = N'(1) << $urandom_range(N - 1);
                2:       mask_in = N'($urandom & $urandom);
                default: mask_in = N'($urandom);
            endcase
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
- Parametrised, registered successor to the combinational register-select decoder. It turns an index into a one-hot register enable for the register file.
- Scan mode adds register-list sequencing for load/store-multiple. A mask is latched and its set bits are emitted one per handshake, ascending or descending.
- Sits between the control unit and the register-file Rin/Rout enables.

Parameters:
- SEL_W, 4, index width; N = 2**SEL_W outputs (derived localparam, not overridable).

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  single-decode request, sampled in IDLE only
- sel_in  in  SEL_W  index for single decode
- start  in  1  scan request, sampled in IDLE only
- mask_in  in  N  register list for scan, latched when start is accepted
- dir  in  1  scan order, latched with mask_in; 0 = lowest index first, 1 = highest first
- ready  in  1  consumer accepts the current output
- onehot_out  out  N  registered one-hot enable; all zero when valid = 0
- index_out  out  SEL_W  binary index of the asserted bit; 0 when valid = 0
- valid  out  1  onehot_out and index_out are meaningful
- last  out  1  qualifies valid; current element is the final one of a scan
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when a scan completes

Behaviour:
- Reset (synchronous): state IDLE; onehot_out, index_out, valid, last, done = 0; the remaining-mask register is cleared.
- Reset during SINGLE or SCAN has the same effect and aborts immediately. No done pulse is generated.
- States: IDLE, SINGLE, SCAN. busy = (state != IDLE).
- IDLE, start = 1 (start has priority over en):
  - Latch dir.
  - pick = first set bit of mask_in in dir order.
  - If mask_in != 0: onehot_out <= 1<<pick; index_out <= pick; valid <= 1; remaining <= mask_in with pick cleared; last <= (remaining == 0); state <= SCAN.
  - If mask_in == 0: valid stays 0; done <= 1 for one cycle; state stays IDLE.
- IDLE, en = 1, start = 0: onehot_out <= 1<<sel_in; index_out <= sel_in; valid <= 1; last <= 0; state <= SINGLE. Latency is one cycle.
- SINGLE:
  - valid = 1 and ready = 1: valid <= 0; outputs return to 0; state <= IDLE.
  - ready = 0: all outputs hold.
- SCAN, handshake (valid = 1 and ready = 1):
  - remaining != 0: emit the next pick of remaining; clear that bit from remaining; last <= (remaining after the clear == 0).
  - remaining == 0 (the element just accepted had last = 1): valid <= 0; last <= 0; done <= 1; state <= IDLE.
- SCAN, ready = 0: all outputs and remaining hold. There are no bubbles between handshakes.
- Throughput: one element per cycle when ready is held high. A K-bit mask gives K valid cycles, then done one cycle after the last handshake.
- start and en are ignored while busy; no queuing. The new request can be accepted in the same cycle done is high, since state is IDLE.
- done is high only for the single cycle after the final handshake. It never coincides with valid.
- Invariant: onehot_out has at most one bit set, and exactly one while valid = 1.

Decomposition:
- Shared package:
  - state enum {IDLE, SINGLE, SCAN}
  - DIR_ASC = 0, DIR_DESC = 1 constants
  - function onehot_of(index)
- Sub-module bit_pick: combinational, parameter N.
  - Inputs: vec[N], dir.
  - Outputs: idx[SEL_W], any.
  - Function: priority-picks the lowest or highest set bit.
  - Instantiated once, on mask_in in IDLE and on remaining in SCAN, selected by state.

Test Plan:
- Reset: assert reset for 2 cycles with start = en = 1 -> all outputs 0, busy = 0 on the cycle after release.
- Single decode: sel_in = 4'hB, en = 1 for 1 cycle, ready = 1 -> next cycle onehot_out = 16'h0800, index_out = 11, valid = 1 for exactly one cycle; done never asserts.
- Ascending scan: mask_in = 16'h8421, dir = 0, start pulse, ready = 1 -> index_out 0, 5, 10, 15 on four consecutive cycles; last = 1 only with 15; done pulse the following cycle.
- Descending scan with stall: mask_in = 16'h0006, dir = 1, ready = 0 on the first valid cycle -> index 2 held 2 cycles, then index 1 with last = 1, then done.
- Empty mask: start with mask_in = 0 -> valid never asserts; done = 1 exactly one cycle after start; busy stays 0.
- Priority, ignore and abort:
  - start and en together -> scan runs.
  - start during SCAN -> ignored.
  - reset after the 2nd element of 16'hFFFF -> outputs 0 next cycle, no done, and a new scan is accepted afterwards.
